// File: rtl/mod_add_fast_eq_core_if.sv
// Operand/result handshake bundle for mod_add_fast_eq_core.
// Carries the optional sub select when MODADD_SUB_EN is defined.
interface mod_add_fast_eq_core_if #(
    parameter int DATA_WIDTH = 32
);
    logic                         start;
    logic signed [DATA_WIDTH-1:0] a;
    logic signed [DATA_WIDTH-1:0] b;
    logic signed [DATA_WIDTH-1:0] Q;
    logic signed [DATA_WIDTH-1:0] out;
    logic                         ready;
    logic                         done;
`ifdef MODADD_SUB_EN
    logic                         sub;
`endif

    modport master (
        output start,
        output a,
        output b,
        output Q,
`ifdef MODADD_SUB_EN
        output sub,
`endif
        input  out,
        input  ready,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  Q,
`ifdef MODADD_SUB_EN
        input  sub,
`endif
        output out,
        output ready,
        output done
    );
endinterface

// File: rtl/mod_add_fast_eq_core.sv
// Three-state modular adder: out = (a+b) mod Q via one conditional subtract.
// Define MODADD_SUB_EN to add a latched sub input selecting (a-b) mod Q.
module mod_add_fast_eq_core #(
    parameter int DATA_WIDTH = 32
) (
    input logic                   clk,
    input logic                   rst,
    mod_add_fast_eq_core_if.slave bus
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   load;

    logic signed [W-1:0] a_r;
    logic signed [W-1:0] b_r;
    logic signed [W-1:0] q_r;
    logic signed [W-1:0] out_r;
    logic signed [W-1:0] res;
    logic signed [W:0]   q_ext;
    logic signed [W:0]   sum;
`ifdef MODADD_SUB_EN
    logic                sub_r;
    logic signed [W:0]   diff;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One widened magnitude compare; sum == Q lands on zero.
    always_comb begin
        q_ext = {q_r[W-1], q_r};
        sum   = {a_r[W-1], a_r} + {b_r[W-1], b_r};
        res   = (sum >= q_ext) ? W'(sum - q_ext) : W'(sum);
`ifdef MODADD_SUB_EN
        diff  = {a_r[W-1], a_r} - {b_r[W-1], b_r};
        if (sub_r) begin
            res = diff[W] ? W'(diff + q_ext) : W'(diff);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r   <= '0;
            b_r   <= '0;
            q_r   <= '0;
            out_r <= '0;
`ifdef MODADD_SUB_EN
            sub_r <= 1'b0;
`endif
        end else begin
            if (load) begin
                a_r   <= bus.a;
                b_r   <= bus.b;
                q_r   <= bus.Q;
`ifdef MODADD_SUB_EN
                sub_r <= bus.sub;
`endif
            end
            if (state == CALC) begin
                out_r <= res;
            end
        end
    end

    assign bus.out   = out_r;
    assign bus.ready = (state == IDLE);
    assign bus.done  = (state == DONE);
endmodule

// File: tb/tb_mod_add_fast_eq_core.sv
// Bench for mod_add_fast_eq_core: directed table, handshake/reset sequences,
// and random operations against a plain-arithmetic modular model.
module tb_mod_add_fast_eq_core;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic         sub;
        logic [W-1:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mod_add_fast_eq_core_if #(.DATA_WIDTH(W)) bus ();

    mod_add_fast_eq_core #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] q,
                                           input logic s);
        longint r;
        if (s) begin
            r = longint'(a) - longint'(b);
            if (r < 0) r = r + longint'(q);
        end else begin
            r = longint'(a) + longint'(b);
            if (r >= longint'(q)) r = r - longint'(q);
        end
        return r[W-1:0];
    endfunction

    task automatic drive(input logic st, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] q,
                         input logic s);
        bus.start = st;
        bus.a     = a;
        bus.b     = b;
        bus.Q     = q;
`ifdef MODADD_SUB_EN
        bus.sub   = s;
`else
        if (s) bus.start = st;
`endif
    endtask

    // Called at a negedge while idle; ends at the negedge after DONE.
    task automatic run_op(input vec_t v, input string tag);
        logic [W-1:0] prev;
        prev = bus.out;
        check({tag, " idle ready"}, W'(bus.ready), W'(1));
        drive(1'b1, v.a, v.b, v.q, v.sub);
        @(negedge clk);
        drive(1'b0, W'($urandom), W'($urandom), W'($urandom), ~v.sub);
        check({tag, " calc ready"}, W'(bus.ready), W'(0));
        check({tag, " calc done"}, W'(bus.done), W'(0));
        check({tag, " calc out held"}, bus.out, prev);
        @(negedge clk);
        check({tag, " done pulse"}, W'(bus.done), W'(1));
        check({tag, " done ready"}, W'(bus.ready), W'(0));
        check({tag, " out"}, bus.out, v.exp);
        @(negedge clk);
        check({tag, " done end"}, W'(bus.done), W'(0));
        check({tag, " ready back"}, W'(bus.ready), W'(1));
        check({tag, " out hold"}, bus.out, v.exp);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        logic [W-1:0] first;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive(1'b0, '0, '0, W'(17), 1'b0);
        #1;
        check("reset out", bus.out, W'(0));
        check("reset ready", W'(bus.ready), W'(1));
        check("reset done", W'(bus.done), W'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        vecs.push_back('{32'h07FF_F800, 32'h0000_0200, 32'h07FF_F801, 1'b0, 32'h0000_01FF});
        vecs.push_back('{32'd5, 32'd3, 32'd17, 1'b0, 32'd8});
        vecs.push_back('{32'd16, 32'd1, 32'd17, 1'b0, 32'd0});
        vecs.push_back('{32'd10, 32'd10, 32'd17, 1'b0, 32'd3});
        vecs.push_back('{32'd0, 32'd0, 32'd2, 1'b0, 32'd0});
        vecs.push_back('{32'd1, 32'd0, 32'd2, 1'b0, 32'd1});
        vecs.push_back('{32'h7FFF_FFFE, 32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFD});
        vecs.push_back('{32'd20, 32'd20, 32'd17, 1'b0, 32'd23});
`ifdef MODADD_SUB_EN
        vecs.push_back('{32'd3, 32'd10, 32'd17, 1'b1, 32'd10});
        vecs.push_back('{32'd10, 32'd3, 32'd17, 1'b1, 32'd7});
        vecs.push_back('{32'd4, 32'd4, 32'd17, 1'b1, 32'd0});
`endif
        foreach (vecs[i]) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start held high: busy-time starts are dropped, new op every 3 cycles
        drive(1'b1, W'(10), W'(10), W'(17), 1'b0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("hold ready k%0d", k), W'(bus.ready), W'(k % 3 == 2));
            check($sformatf("hold done k%0d", k), W'(bus.done), W'(k % 3 == 1));
            if (k % 3 == 1) check($sformatf("hold out k%0d", k), bus.out, W'(3));
        end
        bus.start = 1'b0;

        // a start pulse during CALC must not be queued
        drive(1'b1, W'(5), W'(3), W'(17), 1'b0);
        @(negedge clk);
        drive(1'b1, W'(1), W'(1), W'(17), 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy start out", bus.out, W'(8));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("no queue ready k%0d", k), W'(bus.ready), W'(1));
            check($sformatf("no queue done k%0d", k), W'(bus.done), W'(0));
        end
        check("no queue out", bus.out, W'(8));

        // reset in CALC aborts immediately with no later done
        drive(1'b1, W'(6), W'(6), W'(17), 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst calc out", bus.out, W'(0));
        check("rst calc ready", W'(bus.ready), W'(1));
        check("rst calc done", W'(bus.done), W'(0));
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post rst done k%0d", k), W'(bus.done), W'(0));
            check($sformatf("post rst ready k%0d", k), W'(bus.ready), W'(1));
        end
        check("post rst out", bus.out, W'(0));

        // reset in DONE drops the pulse at once
        drive(1'b1, W'(7), W'(2), W'(17), 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre rst done", W'(bus.done), W'(1));
        #2 rst = 1'b0;
        #1;
        check("rst done pulse", W'(bus.done), W'(0));
        check("rst done out", bus.out, W'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op('{32'd2, 32'd2, 32'd17, 1'b0, 32'd4}, "after rst");

        for (int n = 0; n < 40; n++) begin
            v.q = W'($urandom_range(32'h7FFF_FFFF, 2));
            v.a = W'($urandom_range(v.q - 1, 0));
            v.b = W'($urandom_range(v.q - 1, 0));
`ifdef MODADD_SUB_EN
            v.sub = 1'($urandom_range(1, 0));
`else
            v.sub = 1'b0;
`endif
            v.exp = model(v.a, v.b, v.q, v.sub);
            first = v.exp;
            run_op(v, $sformatf("rand%0d", n));
            check($sformatf("rand%0d range", n), W'(first < v.q), W'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
